mdio_frame_ctrl: RTL and testbench

- Clause-22 MDIO master transaction engine; sits directly downstream of mdio_baud_gen.
- Drives the baud generator enable and consumes its neg/pos strobes.
- Serialises one read or write frame onto the MDIO data line and deserialises read data.
- Host side is a start/busy/done handshake fed by the Wishbone/register layer above.

---
 rtl/mdio_frame_ctrl.sv | 186 ++++++++++++++++++
 tb/tb_mdio_frame_ctrl.sv | 406 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mdio_frame_ctrl.sv
// rtl/mdio_frame_ctrl.sv - Clause-22 MDIO master frame engine driven by mdio_baud_gen strobes.
// Optional MDIO_FRAME_CTRL_TA_CHECK_EN adds op_rd_error (PHY turnaround response check).
module mdio_frame_ctrl #(
    parameter int PREAMBLE_BITS = 32
) (
    input  logic        ip_master_clk,
    input  logic        ip_sync_reset,
    input  logic        ip_start,
    input  logic        ip_op_read,
    input  logic [4:0]  ip_phy_addr,
    input  logic [4:0]  ip_reg_addr,
    input  logic [15:0] ip_wr_data,
    output logic        op_busy,
    output logic        op_done,
    output logic [15:0] op_rd_data,
    output logic        op_baud_enable,
    input  logic        ip_baud_strobe_neg,
    input  logic        ip_baud_strobe_pos,
    output logic        op_mdio_o,
    output logic        op_mdio_oe,
    input  logic        ip_mdio_i
`ifdef MDIO_FRAME_CTRL_TA_CHECK_EN
    ,
    output logic        op_rd_error
`endif
);

    localparam int         FRAME_LEN = PREAMBLE_BITS + 32;
    localparam int         ALIGN     = 32 - PREAMBLE_BITS;
    localparam logic [5:0] LAST_BIT  = 6'(FRAME_LEN - 1);
    localparam logic [5:0] DATA_BIT  = 6'(PREAMBLE_BITS + 16);
`ifdef MDIO_FRAME_CTRL_TA_CHECK_EN
    localparam logic [5:0] TA2_BIT   = 6'(PREAMBLE_BITS + 15);
`endif

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SYNC,
        ST_SHIFT,
        ST_FINISH
    } state_t;

    state_t      state;
    state_t      state_next;

    logic [63:0] tx_bits;
    logic [63:0] tx_oe;
    logic [31:0] hdr_bits;
    logic [31:0] hdr_oe;
    logic [5:0]  bit_cnt;
    logic        read_q;
    logic [15:0] rx_shift;
    logic        last_neg;
`ifdef MDIO_FRAME_CTRL_TA_CHECK_EN
    logic        ta_sample;
`endif

    // Header after the preamble, MSB first; read TA/data drive idle '1' while released.
    always_comb begin
        hdr_bits = {2'b01,
                    (ip_op_read ? 2'b10 : 2'b01),
                    ip_phy_addr,
                    ip_reg_addr,
                    (ip_op_read ? 2'b11 : 2'b10),
                    (ip_op_read ? 16'hFFFF : ip_wr_data)};
        hdr_oe   = ip_op_read ? {14'h3FFF, 18'h00000} : 32'hFFFF_FFFF;
    end

    assign last_neg = (state == ST_SHIFT) && ip_baud_strobe_neg && (bit_cnt == LAST_BIT);

    always_ff @(posedge ip_master_clk) begin
        if (ip_sync_reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next     = state;
        op_busy        = 1'b0;
        op_done        = 1'b0;
        op_baud_enable = 1'b0;
        case (state)
            ST_IDLE: begin
                if (ip_start) begin
                    state_next = ST_SYNC;
                end
            end
            ST_SYNC: begin
                op_busy        = 1'b1;
                op_baud_enable = 1'b1;
                if (ip_baud_strobe_neg) begin
                    state_next = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                op_busy        = 1'b1;
                op_baud_enable = 1'b1;
                if (last_neg) begin
                    state_next = ST_FINISH;
                end
            end
            ST_FINISH: begin
                op_busy    = 1'b1;
                op_done    = 1'b1;
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // Frame is held left-aligned in tx_bits/tx_oe; bit 63 is the next bit onto the line.
    always_ff @(posedge ip_master_clk) begin
        if (ip_sync_reset) begin
            tx_bits    <= '0;
            tx_oe      <= '0;
            bit_cnt    <= '0;
            read_q     <= 1'b0;
            rx_shift   <= '0;
            op_mdio_o  <= 1'b1;
            op_mdio_oe <= 1'b0;
            op_rd_data <= '0;
`ifdef MDIO_FRAME_CTRL_TA_CHECK_EN
            ta_sample   <= 1'b1;
            op_rd_error <= 1'b0;
`endif
        end else begin
            case (state)
                ST_IDLE: begin
                    if (ip_start) begin
                        tx_bits <= {32'hFFFF_FFFF, hdr_bits} << ALIGN;
                        tx_oe   <= {32'hFFFF_FFFF, hdr_oe} << ALIGN;
                        read_q  <= ip_op_read;
                        bit_cnt <= '0;
`ifdef MDIO_FRAME_CTRL_TA_CHECK_EN
                        op_rd_error <= 1'b0;
`endif
                    end
                end
                ST_SYNC: begin
                    if (ip_baud_strobe_neg) begin
                        op_mdio_o  <= tx_bits[63];
                        op_mdio_oe <= tx_oe[63];
                        tx_bits    <= tx_bits << 1;
                        tx_oe      <= tx_oe << 1;
                    end
                end
                ST_SHIFT: begin
                    if (ip_baud_strobe_neg) begin
                        if (bit_cnt == LAST_BIT) begin
                            op_mdio_o  <= 1'b1;
                            op_mdio_oe <= 1'b0;
                            if (read_q) begin
                                op_rd_data <= rx_shift;
                            end
`ifdef MDIO_FRAME_CTRL_TA_CHECK_EN
                            op_rd_error <= read_q & ta_sample;
`endif
                        end else begin
                            bit_cnt    <= bit_cnt + 6'd1;
                            op_mdio_o  <= tx_bits[63];
                            op_mdio_oe <= tx_oe[63];
                            tx_bits    <= tx_bits << 1;
                            tx_oe      <= tx_oe << 1;
                        end
                    end else if (ip_baud_strobe_pos && read_q) begin
                        if (bit_cnt >= DATA_BIT) begin
                            rx_shift <= {rx_shift[14:0], ip_mdio_i};
                        end
`ifdef MDIO_FRAME_CTRL_TA_CHECK_EN
                        if (bit_cnt == TA2_BIT) begin
                            ta_sample <= ip_mdio_i;
                        end
`endif
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mdio_frame_ctrl.sv
// tb/tb_mdio_frame_ctrl.sv - randomized self-checking bench for mdio_frame_ctrl (32-bit and no-preamble builds).
module tb_mdio_frame_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        start [2];
    logic        op_rd [2];
    logic [4:0]  phy   [2];
    logic [4:0]  regad [2];
    logic [15:0] wdat  [2];
    logic        busy  [2];
    logic        done  [2];
    logic [15:0] rdd   [2];
    logic        en    [2];
    logic        sneg  [2];
    logic        spos  [2];
    logic        mo    [2];
    logic        moe   [2];
    logic        mi    [2];
`ifdef MDIO_FRAME_CTRL_TA_CHECK_EN
    logic        rde   [2];
`endif

    int          bit_idx  [2];
    int          nsamp    [2];
    int          done_cnt [2];
    int          half     [2];
    logic        so  [2][64];
    logic        soe [2][64];
    logic        sb  [2][64];

    logic        e_rd    [2];
    logic [4:0]  e_phy   [2];
    logic [4:0]  e_reg   [2];
    logic [15:0] e_dat   [2];
    logic        present [2];
    logic [15:0] last_rd [2];

    int          errors = 0;
    int          checks = 0;

    always #5 clk = ~clk;

    function automatic int npre(input int g);
        return (g == 0) ? 32 : 0;
    endfunction

    // Line value of bit i of the frame as listed by Clause 22.
    function automatic logic exp_o(input int g, input int i);
        int         n;
        int         j;
        logic [4:0] t5;
        logic [15:0] t16;
        n = npre(g);
        j = i - n;
        if (i < n) return 1'b1;
        if (j == 0) return 1'b0;
        if (j == 1) return 1'b1;
        if (j == 2) return e_rd[g];
        if (j == 3) return ~e_rd[g];
        if (j <= 8) begin
            t5 = e_phy[g] >> (8 - j);
            return t5[0];
        end
        if (j <= 13) begin
            t5 = e_reg[g] >> (13 - j);
            return t5[0];
        end
        if (j == 14) return 1'b1;
        if (j == 15) return 1'b0;
        t16 = e_dat[g] >> (31 - j);
        return t16[0];
    endfunction

    function automatic logic exp_oe(input int g, input int i);
        return !(e_rd[g] && (i - npre(g) >= 14));
    endfunction

    // PHY model: drives TA2=0 and data during reads when present, else the pull-up gives 1.
    function automatic logic phy_drive(input int g, input int idx);
        int          j;
        logic [15:0] t16;
        if (!e_rd[g] || !present[g] || idx < 0) return 1'b1;
        j = idx - npre(g);
        if (j == 15) return 1'b0;
        if (j >= 16 && j <= 31) begin
            t16 = e_dat[g] >> (31 - j);
            return t16[0];
        end
        return 1'b1;
    endfunction

    for (genvar g = 0; g < 2; g++) begin : gi
        mdio_frame_ctrl #(.PREAMBLE_BITS((g == 0) ? 32 : 0)) dut (
            .ip_master_clk      (clk),
            .ip_sync_reset      (rst),
            .ip_start           (start[g]),
            .ip_op_read         (op_rd[g]),
            .ip_phy_addr        (phy[g]),
            .ip_reg_addr        (regad[g]),
            .ip_wr_data         (wdat[g]),
            .op_busy            (busy[g]),
            .op_done            (done[g]),
            .op_rd_data         (rdd[g]),
            .op_baud_enable     (en[g]),
            .ip_baud_strobe_neg (sneg[g]),
            .ip_baud_strobe_pos (spos[g]),
            .op_mdio_o          (mo[g]),
            .op_mdio_oe         (moe[g]),
            .ip_mdio_i          (mi[g])
`ifdef MDIO_FRAME_CTRL_TA_CHECK_EN
            ,
            .op_rd_error        (rde[g])
`endif
        );

        // Baud generator model, MDC-rising line sampler and PHY driver.
        initial begin : mon
            int   cnt;
            logic nxt_neg;
            logic wn;
            logic wp;
            cnt         = 0;
            nxt_neg     = 1'b1;
            sneg[g]     = 1'b0;
            spos[g]     = 1'b0;
            mi[g]       = 1'b1;
            bit_idx[g]  = -1;
            nsamp[g]    = 0;
            done_cnt[g] = 0;
            half[g]     = 2;
            forever begin
                @(posedge clk);
                wn = sneg[g];
                wp = spos[g];
                #1;
                if (done[g] === 1'b1) done_cnt[g]++;
                if (wp && busy[g] === 1'b1 && nsamp[g] < 64) begin
                    so[g][nsamp[g]]  = mo[g];
                    soe[g][nsamp[g]] = moe[g];
                    sb[g][nsamp[g]]  = busy[g];
                    nsamp[g]++;
                end
                if (wn && busy[g] === 1'b1) bit_idx[g]++;
                sneg[g] = 1'b0;
                spos[g] = 1'b0;
                if (en[g] !== 1'b1) begin
                    cnt        = 0;
                    nxt_neg    = 1'b1;
                    bit_idx[g] = -1;
                end else begin
                    cnt++;
                    if (cnt >= half[g]) begin
                        cnt = 0;
                        if (nxt_neg) sneg[g] = 1'b1;
                        else spos[g] = 1'b1;
                        nxt_neg = ~nxt_neg;
                    end
                end
                mi[g] = phy_drive(g, bit_idx[g]);
            end
        end
    end

    task automatic start_frame(input int g, input logic rd, input logic [4:0] p, input logic [4:0] r,
                               input logic [15:0] d, input logic pres);
        e_rd[g]    = rd;
        e_phy[g]   = p;
        e_reg[g]   = r;
        e_dat[g]   = d;
        present[g] = pres;
        @(posedge clk);
        #1;
        checks++;
        if (busy[g] !== 1'b0) begin
            errors++;
            $display("FAIL start_idle_busy[%0d]: got %b expected 0", g, busy[g]);
        end
        op_rd[g]    = rd;
        phy[g]      = p;
        regad[g]    = r;
        wdat[g]     = d;
        nsamp[g]    = 0;
        done_cnt[g] = 0;
        start[g]    = 1'b1;
        @(posedge clk);
        #1;
        start[g] = 1'b0;
        checks++;
        if (busy[g] !== 1'b1 || en[g] !== 1'b1) begin
            errors++;
            $display("FAIL accept[%0d]: got busy=%b en=%b expected 1 1", g, busy[g], en[g]);
        end
`ifdef MDIO_FRAME_CTRL_TA_CHECK_EN
        checks++;
        if (rde[g] !== 1'b0) begin
            errors++;
            $display("FAIL rd_error_clear[%0d]: got %b expected 0", g, rde[g]);
        end
`endif
    endtask

    task automatic finish_frame(input int g);
        int   cyc;
        int   len;
        logic ee;
        cyc = 0;
        len = npre(g) + 32;
        while (done_cnt[g] == 0 && cyc < 5000) begin
            @(negedge clk);
            cyc++;
        end
        checks++;
        if (done_cnt[g] == 0) begin
            errors++;
            $display("FAIL done_timeout[%0d]: got no done expected done", g);
            return;
        end
        if (e_rd[g]) last_rd[g] = present[g] ? e_dat[g] : 16'hFFFF;
        checks++;
        if (rdd[g] !== last_rd[g]) begin
            errors++;
            $display("FAIL rd_data[%0d]: got %h expected %h", g, rdd[g], last_rd[g]);
        end
`ifdef MDIO_FRAME_CTRL_TA_CHECK_EN
        ee = e_rd[g] && !present[g];
        checks++;
        if (rde[g] !== ee) begin
            errors++;
            $display("FAIL rd_error[%0d]: got %b expected %b", g, rde[g], ee);
        end
`else
        ee = 1'b0;
`endif
        checks++;
        if (nsamp[g] != len) begin
            errors++;
            $display("FAIL mdc_periods[%0d]: got %0d expected %0d", g, nsamp[g], len);
        end
        for (int i = 0; i < len; i++) begin
            checks++;
            if (soe[g][i] !== exp_oe(g, i) || sb[g][i] !== 1'b1 ||
                (exp_oe(g, i) && so[g][i] !== exp_o(g, i))) begin
                errors++;
                $display("FAIL frame_bit[%0d][%0d]: got o=%b oe=%b busy=%b expected o=%b oe=%b busy=1",
                         g, i, so[g][i], soe[g][i], sb[g][i], exp_o(g, i), exp_oe(g, i));
            end
        end
    endtask

    task automatic check_idle(input int g, input string name, input logic [15:0] exp_rd);
        checks++;
        if (mo[g] !== 1'b1 || moe[g] !== 1'b0 || en[g] !== 1'b0 || busy[g] !== 1'b0 ||
            done[g] !== 1'b0 || rdd[g] !== exp_rd) begin
            errors++;
            $display("FAIL %s[%0d]: got o=%b oe=%b en=%b busy=%b done=%b rd=%h expected 1 0 0 0 0 %h",
                     name, g, mo[g], moe[g], en[g], busy[g], done[g], rdd[g], exp_rd);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        for (int g = 0; g < 2; g++) begin
            last_rd[g]  = 16'h0000;
            check_idle(g, "reset", 16'h0000);
            done_cnt[g] = 0;
        end
        repeat (100) @(negedge clk);
        for (int g = 0; g < 2; g++) begin
            check_idle(g, "idle100", 16'h0000);
            checks++;
            if (done_cnt[g] != 0) begin
                errors++;
                $display("FAIL idle_done[%0d]: got %0d pulses expected 0", g, done_cnt[g]);
            end
        end
    endtask

    task automatic test_write();
        half[0] = 2;
        start_frame(0, 1'b0, 5'h01, 5'h00, 16'h1234, 1'b1);
        finish_frame(0);
    endtask

    task automatic test_read();
        half[0] = 2;
        start_frame(0, 1'b1, 5'h1F, 5'h02, 16'hA5C3, 1'b1);
        finish_frame(0);
        start_frame(0, 1'b1, 5'h03, 5'h11, 16'h0F0F, 1'b0);
        finish_frame(0);
    endtask

    task automatic test_preamble0();
        half[1] = 2;
        start_frame(1, 1'b0, 5'h03, 5'h07, 16'hBEEF, 1'b1);
        finish_frame(1);
        start_frame(1, 1'b1, 5'h15, 5'h0A, 16'h8001, 1'b1);
        finish_frame(1);
    endtask

    task automatic test_random();
        for (int k = 0; k < 8; k++) begin
            int g;
            g       = int'($urandom_range(0, 1));
            half[g] = int'($urandom_range(2, 5));
            start_frame(g, 1'($urandom), 5'($urandom), 5'($urandom), 16'($urandom), 1'($urandom));
            finish_frame(g);
        end
    endtask

    task automatic test_back_to_back();
        half[0] = 3;
        for (int k = 0; k < 3; k++) begin
            start_frame(0, 1'($urandom), 5'($urandom), 5'($urandom), 16'($urandom), 1'b1);
            finish_frame(0);
        end
    endtask

    task automatic test_ignore_start();
        int cyc;
        half[0] = 2;
        start_frame(0, 1'b1, 5'h0A, 5'h15, 16'h5A5A, 1'b1);
        cyc = 0;
        while (bit_idx[0] < 20 && cyc < 3000) begin
            @(negedge clk);
            cyc++;
        end
        op_rd[0] = 1'b0;
        phy[0]   = 5'h1F;
        regad[0] = 5'h1F;
        wdat[0]  = 16'hFFFF;
        start[0] = 1'b1;
        @(negedge clk);
        start[0] = 1'b0;
        finish_frame(0);
        repeat (10) @(negedge clk);
        checks++;
        if (done_cnt[0] != 1 || busy[0] !== 1'b0) begin
            errors++;
            $display("FAIL single_done: got pulses=%0d busy=%b expected 1 0", done_cnt[0], busy[0]);
        end
    endtask

    task automatic test_reset_mid();
        int cyc;
        half[0] = 2;
        start_frame(0, 1'b0, 5'h12, 5'h09, 16'hC0DE, 1'b1);
        cyc = 0;
        while (bit_idx[0] != 40 && cyc < 3000) begin
            @(negedge clk);
            cyc++;
        end
        checks++;
        if (bit_idx[0] != 40) begin
            errors++;
            $display("FAIL reach_bit40: got %0d expected 40", bit_idx[0]);
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        for (int g = 0; g < 2; g++) begin
            last_rd[g] = 16'h0000;
            check_idle(g, "reset_mid", 16'h0000);
        end
        repeat (20) @(negedge clk);
        checks++;
        if (done_cnt[0] != 0 || busy[0] !== 1'b0) begin
            errors++;
            $display("FAIL reset_no_done: got pulses=%0d busy=%b expected 0 0", done_cnt[0], busy[0]);
        end
        start_frame(0, 1'b1, 5'h07, 5'h1C, 16'h3C96, 1'b1);
        finish_frame(0);
    endtask

    initial begin
        rst = 1'b1;
        for (int g = 0; g < 2; g++) begin
            start[g]   = 1'b0;
            op_rd[g]   = 1'b0;
            phy[g]     = 5'h00;
            regad[g]   = 5'h00;
            wdat[g]    = 16'h0000;
            e_rd[g]    = 1'b0;
            e_phy[g]   = 5'h00;
            e_reg[g]   = 5'h00;
            e_dat[g]   = 16'h0000;
            present[g] = 1'b0;
            last_rd[g] = 16'h0000;
        end
        test_reset();
        test_write();
        test_read();
        test_preamble0();
        test_random();
        test_back_to_back();
        test_ignore_start();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
